audio_gain_stage: RTL and testbench



---
 rtl/audio_pkg.sv | 54 +++++
 rtl/audio_gain_stage_if.sv | 17 +
 rtl/audio_gain_ramp.sv | 64 ++++++
 rtl/audio_gain_stage.sv | 146 ++++++++++++++
 tb/tb_audio_gain_stage.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the audio DSP blocks: default sample/gain widths,
// the gain-stage FSM state type and a round-and-saturate helper that turns a
// wide fixed-point product back into a sample.
// No ports (package).
// -----------------------------------------------------------------------------
package audio_pkg;

    localparam int DATA_W_DEF = 24;
    localparam int GAIN_W_DEF = 8;
    localparam int FRAC_W_DEF = 7;

    // Working width of the rounding helper; any product up to this width fits.
    localparam int ACC_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        OUT  = 2'd2
    } state_t;

    typedef struct packed {
        logic signed [ACC_W-1:0] value;   // rounded, saturated sample (sign-extended)
        logic                    clipped; // saturation occurred
    } sat_t;

    // Round half toward +inf by adding half an LSB and shifting arithmetically,
    // then clamp into a data_w-bit two's-complement range.
    function automatic sat_t round_sat(input logic signed [ACC_W-1:0] p,
                                       input int frac_w,
                                       input int data_w);
        logic signed [ACC_W-1:0] half;
        logic signed [ACC_W-1:0] r;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        sat_t                    res;
        half        = 64'sd1 <<< (frac_w - 1);
        r           = (p + half) >>> frac_w;
        hi          = (64'sd1 <<< (data_w - 1)) - 64'sd1;
        lo          = -hi - 64'sd1;
        res.value   = r;
        res.clipped = 1'b0;
        if (r > hi) begin
            res.value   = hi;
            res.clipped = 1'b1;
        end else if (r < lo) begin
            res.value   = lo;
            res.clipped = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/audio_gain_stage_if.sv
// -----------------------------------------------------------------------------
// audio_gain_stage_if
// Valid/ready frame stream carrying one packed multi-channel frame.
//   valid  master->slave  frame present
//   ready  slave->master  frame accepted when valid & ready at a clock edge
//   data   master->slave  packed frame, W bits
// -----------------------------------------------------------------------------
interface audio_gain_stage_if #(
    parameter int W = 48
);
    logic         valid;
    logic         ready;
    logic [W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/audio_gain_ramp.sv
// -----------------------------------------------------------------------------
// audio_gain_ramp
// Holds the gain target, applies mute, and walks the current gain toward the
// effective target by at most RAMP_STEP each time step_en is pulsed.
//   clk, reset   clock, asynchronous active-high reset
//   step_en      advance the current gain by one ramp step
//   load         latch target into the target register
//   target       requested gain
//   mute         force the effective target to zero while high
//   gain_current gain to apply to the next accepted frame
// -----------------------------------------------------------------------------
module audio_gain_ramp
    import audio_pkg::*;
#(
    parameter int GAIN_W    = GAIN_W_DEF,
    parameter int FRAC_W    = FRAC_W_DEF,
    parameter int RAMP_STEP = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_en,
    input  logic              load,
    input  logic [GAIN_W-1:0] target,
    input  logic              mute,
    output logic [GAIN_W-1:0] gain_current
);

    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1) << FRAC_W;
    localparam logic [GAIN_W-1:0] STEP  = GAIN_W'(RAMP_STEP);

    logic [GAIN_W-1:0] target_q, target_d;
    logic [GAIN_W-1:0] cur_q, cur_d;
    logic [GAIN_W-1:0] eff;

    // The step reads target_q, so a load on the step cycle only affects later steps.
    assign eff = mute ? '0 : target_q;

    always_comb begin
        target_d = load ? target : target_q;
        cur_d    = cur_q;
        if (step_en) begin
            if (cur_q < eff) begin
                cur_d = (eff - cur_q > STEP) ? cur_q + STEP : eff;
            end else if (cur_q > eff) begin
                cur_d = (cur_q - eff > STEP) ? cur_q - STEP : eff;
            end
        end
    end

    // NOTE: state registers update with non-blocking assignments so every flop
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            target_q <= UNITY;
            cur_q    <= UNITY;
        end else begin
            target_q <= target_d;
            cur_q    <= cur_d;
        end
    end

    assign gain_current = cur_q;

endmodule

// File: rtl/audio_gain_stage.sv
// -----------------------------------------------------------------------------
// audio_gain_stage
// Multiplies every channel of a frame by a shared, smoothly ramped fixed-point
// gain using one multiplier time-shared across channels, then rounds and
// saturates. Sticky per-channel clip flags report saturation.
//   CLOCK_50      clock, rising edge
//   reset         asynchronous active-high reset
//   gain_target   requested gain, latched on gain_load
//   gain_load     one-cycle target strobe
//   mute          level; effective target is 0 while high
//   clip_clr      clears all clip flags (a same-cycle new clip wins)
//   in_if         slave stream, NCH*DATA_W packed input frame
//   out_if        master stream, NCH*DATA_W registered output frame
//   gain_current  gain applied to the next accepted frame
//   clip          sticky per-channel saturation flags
// -----------------------------------------------------------------------------
module audio_gain_stage
    import audio_pkg::*;
#(
    parameter int DATA_W    = DATA_W_DEF,
    parameter int NCH       = 2,
    parameter int GAIN_W    = GAIN_W_DEF,
    parameter int FRAC_W    = FRAC_W_DEF,
    parameter int RAMP_STEP = 1
) (
    input  logic                CLOCK_50,
    input  logic                reset,
    input  logic [GAIN_W-1:0]   gain_target,
    input  logic                gain_load,
    input  logic                mute,
    input  logic                clip_clr,
    audio_gain_stage_if.slave   in_if,
    audio_gain_stage_if.master  out_if,
    output logic [GAIN_W-1:0]   gain_current,
    output logic [NCH-1:0]      clip
);

    localparam int CH_W    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PROD_W  = DATA_W + GAIN_W + 1;
    localparam int FRAME_W = NCH * DATA_W;
    localparam logic [GAIN_W-1:0] UNITY = GAIN_W'(1) << FRAC_W;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ch_q, ch_d;
    logic [FRAME_W-1:0]  frame_q, frame_d;
    logic [GAIN_W-1:0]   gain_frame_q, gain_frame_d;
    logic [FRAME_W-1:0]  out_data_q, out_data_d;
    logic [NCH-1:0]      clip_q, clip_d;

    logic signed [DATA_W-1:0] sample;
    logic signed [GAIN_W:0]   gain_s;
    logic signed [PROD_W-1:0] product;
    sat_t                     sat;
    logic                     step_en;

    // Single multiplier: the channel selected by ch_q times the frame gain,
    // treated as a non-negative signed operand.
    assign sample  = frame_q[ch_q*DATA_W +: DATA_W];
    assign gain_s  = {1'b0, gain_frame_q};
    assign product = PROD_W'(sample) * PROD_W'(gain_s);
    assign sat     = round_sat(ACC_W'(product), FRAC_W, DATA_W);

    // The ramp only advances when a finished frame leaves the block.
    assign step_en = (state_q == OUT) && out_if.ready;

    audio_gain_ramp #(
        .GAIN_W    (GAIN_W),
        .FRAC_W    (FRAC_W),
        .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
        .clk          (CLOCK_50),
        .reset        (reset),
        .step_en      (step_en),
        .load         (gain_load),
        .target       (gain_target),
        .mute         (mute),
        .gain_current (gain_current)
    );

    // NOTE: every combinational output takes its hold value first, so no path
    // through the case leaves a signal unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        frame_d      = frame_q;
        gain_frame_d = gain_frame_q;
        out_data_d   = out_data_q;
        clip_d       = clip_q;
        if (clip_clr) begin
            clip_d = '0;
        end
        case (state_q)
            IDLE: begin
                if (in_if.valid) begin
                    frame_d      = in_if.data;
                    gain_frame_d = gain_current;
                    ch_d         = '0;
                    state_d      = MUL;
                end
            end
            MUL: begin
                out_data_d[ch_q*DATA_W +: DATA_W] = DATA_W'(sat.value);
                if (sat.clipped) begin
                    clip_d[ch_q] = 1'b1;
                end
                if (ch_q == CH_W'(NCH - 1)) begin
                    state_d = OUT;
                end else begin
                    ch_d = ch_q + CH_W'(1);
                end
            end
            OUT: begin
                if (out_if.ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: the frame buffer is only a few flops, so it is reset along with the
    // control state; an in-flight frame is discarded cleanly on reset.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            ch_q         <= '0;
            frame_q      <= '0;
            gain_frame_q <= UNITY;
            out_data_q   <= '0;
            clip_q       <= '0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            frame_q      <= frame_d;
            gain_frame_q <= gain_frame_d;
            out_data_q   <= out_data_d;
            clip_q       <= clip_d;
        end
    end

    assign in_if.ready  = (state_q == IDLE) && !reset;
    assign out_if.valid = (state_q == OUT);
    assign out_if.data  = out_data_q;
    assign clip         = clip_q;

endmodule

// File: tb/tb_audio_gain_stage.sv
// -----------------------------------------------------------------------------
// tb_audio_gain_stage
// Directed and randomized frames against a behavioural model of the gain
// stage: integer arithmetic for scaling/rounding/saturation, a simple
// step-toward-target ramp, and sticky clip flags.
// -----------------------------------------------------------------------------
module tb_audio_gain_stage;

    localparam int DATA_W    = 24;
    localparam int NCH       = 2;
    localparam int GAIN_W    = 8;
    localparam int FRAC_W    = 7;
    localparam int RAMP_STEP = 1;
    localparam int FW        = NCH * DATA_W;
    localparam int UNITY     = 1 << FRAC_W;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [GAIN_W-1:0] gain_target = '0;
    logic              gain_load = 1'b0;
    logic              mute = 1'b0;
    logic              clip_clr = 1'b0;
    logic [GAIN_W-1:0] gain_current;
    logic [NCH-1:0]    clip;

    audio_gain_stage_if #(.W(FW)) in_if ();
    audio_gain_stage_if #(.W(FW)) out_if ();

    audio_gain_stage #(
        .DATA_W    (DATA_W),
        .NCH       (NCH),
        .GAIN_W    (GAIN_W),
        .FRAC_W    (FRAC_W),
        .RAMP_STEP (RAMP_STEP)
    ) dut (
        .CLOCK_50     (clk),
        .reset        (reset),
        .gain_target  (gain_target),
        .gain_load    (gain_load),
        .mute         (mute),
        .clip_clr     (clip_clr),
        .in_if        (in_if),
        .out_if       (out_if),
        .gain_current (gain_current),
        .clip         (clip)
    );

    always #10 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int             m_target;
    int             m_cur;
    bit             m_mute;
    logic [NCH-1:0] m_clip;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // sample * gain / 2^FRAC_W, rounded half up, clamped to the sample range
    function automatic logic [DATA_W-1:0] scale(input logic [DATA_W-1:0] s, input int g,
                                                output bit clipped);
        longint p, r, hi, lo;
        hi = (longint'(1) << (DATA_W - 1)) - 1;
        lo = -hi - 1;
        p  = longint'($signed(s)) * longint'(g);
        r  = (p + (longint'(1) << (FRAC_W - 1))) >>> FRAC_W;
        clipped = 1'b0;
        if (r > hi) begin
            r = hi;
            clipped = 1'b1;
        end else if (r < lo) begin
            r = lo;
            clipped = 1'b1;
        end
        return r[DATA_W-1:0];
    endfunction

    function automatic int ramp_toward(input int cur, input int eff);
        if (cur < eff) return (eff - cur > RAMP_STEP) ? cur + RAMP_STEP : eff;
        if (cur > eff) return (cur - eff > RAMP_STEP) ? cur - RAMP_STEP : eff;
        return cur;
    endfunction

    task automatic model_reset();
        m_target = UNITY;
        m_cur    = UNITY;
        m_clip   = '0;
    endtask

    task automatic load_gain(input int v);
        @(negedge clk);
        gain_target = GAIN_W'(v);
        gain_load   = 1'b1;
        @(negedge clk);
        gain_load   = 1'b0;
        m_target    = v;
    endtask

    // One full frame: accept, wait for the result, optionally hold the output
    // under backpressure, then consume it (optionally with a same-cycle load).
    task automatic do_frame(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r,
                            input int hold, input bit do_load, input int load_val,
                            input bit clr_mul0, input string tag);
        logic [FW-1:0]  exp_data;
        logic [NCH-1:0] fclip;
        bit             c;
        int             n;
        int             g;
        @(negedge clk);
        n = 0;
        while (!in_if.ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "/in_ready"}, 64'(in_if.ready), 64'd1);
        if (!in_if.ready) return;
        g = m_cur;
        exp_data[DATA_W-1:0]  = scale(l, g, c);
        fclip[0]              = c;
        exp_data[FW-1:DATA_W] = scale(r, g, c);
        fclip[1]              = c;
        out_if.ready = (hold == 0);
        in_if.data   = {r, l};
        in_if.valid  = 1'b1;
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        if (clr_mul0) begin
            clip_clr = 1'b1;
            m_clip   = '0;
        end
        m_clip = m_clip | fclip;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            clip_clr = 1'b0;
            n++;
        end while (!out_if.valid && n < 20);
        check({tag, "/latency"}, 64'(n), 64'(NCH));
        check({tag, "/data"}, 64'(out_if.data), 64'(exp_data));
        check({tag, "/clip"}, 64'(clip), 64'(m_clip));
        check({tag, "/gain_held"}, 64'(gain_current), 64'(m_cur));
        check({tag, "/ready_low"}, 64'(in_if.ready), 64'd0);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            check({tag, "/bp_valid"}, 64'(out_if.valid), 64'd1);
            check({tag, "/bp_data"}, 64'(out_if.data), 64'(exp_data));
            check({tag, "/bp_in_ready"}, 64'(in_if.ready), 64'd0);
            check({tag, "/bp_gain"}, 64'(gain_current), 64'(m_cur));
        end
        out_if.ready = 1'b1;
        if (do_load) begin
            gain_target = GAIN_W'(load_val);
            gain_load   = 1'b1;
        end
        @(posedge clk);
        #1;
        gain_load = 1'b0;
        m_cur = ramp_toward(m_cur, m_mute ? 0 : m_target);
        if (do_load) m_target = load_val;
        check({tag, "/step"}, 64'(gain_current), 64'(m_cur));
        check({tag, "/valid_drop"}, 64'(out_if.valid), 64'd0);
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  n;
        bit  seen;
        in_if.valid  = 1'b0;
        in_if.data   = '0;
        out_if.ready = 1'b1;
        model_reset();
        m_mute = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst/in_ready", 64'(in_if.ready), 64'd0);
        check("rst/out_valid", 64'(out_if.valid), 64'd0);
        check("rst/out_data", 64'(out_if.data), 64'd0);
        check("rst/clip", 64'(clip), 64'd0);
        check("rst/gain", 64'(gain_current), 64'(UNITY));
        reset = 1'b0;
        #1;
        check("rst/in_ready_after", 64'(in_if.ready), 64'd1);

        // Unity passthrough
        do_frame(24'h123456, 24'hFEDCBA, 0, 1'b0, 0, 1'b0, "unity");
        check("unity/exact", 64'(out_if.data), 64'({24'hFEDCBA, 24'h123456}));

        // Ramp down to 64 with constant 256 input
        load_gain(64);
        for (int f = 0; f < 70; f++) do_frame(24'd256, 24'd256, 0, 1'b0, 0, 1'b0, "ramp");
        check("ramp/final_gain", 64'(gain_current), 64'd64);
        check("ramp/final_out", 64'(out_if.data), 64'({24'd128, 24'd128}));

        // Rounding at gain 64
        do_frame(24'hFFFFFF, 24'd3, 0, 1'b0, 0, 1'b0, "round");
        check("round/exact", 64'(out_if.data), 64'({24'd2, 24'd0}));

        // Ramp up to 255 under random data
        load_gain(255);
        n = 0;
        while (m_cur != 255 && n < 300) begin
            do_frame(DATA_W'($urandom), DATA_W'($urandom), 0, 1'b0, 0, 1'b0, "rise");
            n++;
        end
        check("rise/gain", 64'(gain_current), 64'd255);

        // Saturation, clear racing a new clip, then a plain clear
        do_frame(24'h7FFFFF, 24'h800000, 0, 1'b0, 0, 1'b0, "sat");
        check("sat/exact", 64'(out_if.data), 64'({24'h800000, 24'h7FFFFF}));
        check("sat/clip", 64'(clip), 64'b11);
        do_frame(24'h7FFFFF, 24'h800000, 0, 1'b0, 0, 1'b1, "sat_clr_race");
        @(negedge clk);
        clip_clr = 1'b1;
        @(negedge clk);
        clip_clr = 1'b0;
        m_clip = '0;
        check("clip_clr", 64'(clip), 64'd0);

        // Backpressure for 10 cycles, one step on release
        load_gain(100);
        do_frame(24'h7FFFFF, DATA_W'($urandom_range(0, 1000)), 10, 1'b0, 0, 1'b0, "bp");
        check("bp/one_step", 64'(gain_current), 64'd254);

        // Reset in the middle of MUL
        @(negedge clk);
        in_if.data  = {24'h000111, 24'h000222};
        in_if.valid = 1'b1;
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
        #3;
        reset = 1'b1;
        #1;
        check("midrst/out_valid", 64'(out_if.valid), 64'd0);
        check("midrst/gain", 64'(gain_current), 64'(UNITY));
        check("midrst/clip", 64'(clip), 64'd0);
        check("midrst/in_ready", 64'(in_if.ready), 64'd0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            if (out_if.valid) seen = 1'b1;
        end
        check("midrst/no_pulse", 64'(seen), 64'd0);
        do_frame(24'h123456, 24'hFEDCBA, 0, 1'b0, 0, 1'b0, "post_rst");

        // Randomized frames, loads (including on the step edge), clears, backpressure
        for (int f = 0; f < 40; f++) begin
            do_frame(DATA_W'($urandom), DATA_W'($urandom), int'($urandom_range(0, 3)),
                     $urandom_range(0, 3) == 0, int'($urandom_range(0, 255)),
                     $urandom_range(0, 9) == 0, "rand");
        end

        // Mute ramps to zero, unmute ramps back to the target
        load_gain(200);
        @(negedge clk);
        mute   = 1'b1;
        m_mute = 1'b1;
        n = 0;
        while (m_cur != 0 && n < 300) begin
            do_frame(DATA_W'($urandom), DATA_W'($urandom), 0, 1'b0, 0, 1'b0, "mute");
            n++;
        end
        check("mute/gain0", 64'(gain_current), 64'd0);
        do_frame(DATA_W'($urandom), DATA_W'($urandom), 0, 1'b0, 0, 1'b0, "mute_out");
        check("mute/out0", 64'(out_if.data), 64'd0);
        @(negedge clk);
        mute   = 1'b0;
        m_mute = 1'b0;
        n = 0;
        while (m_cur != m_target && n < 300) begin
            do_frame(DATA_W'($urandom), DATA_W'($urandom), 0, 1'b0, 0, 1'b0, "unmute");
            n++;
        end
        check("unmute/gain", 64'(gain_current), 64'd200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
